vtage_update_ctrl: RTL and testbench

Feedback update controller for the VTAGE value predictor. It accepts up to `P_NUM_PRED` validation results per cycle from the feedback interface and buffers them in a small FIFO. It computes the new confidence, usefulness and value fields for each result and serializes them, one per cycle, onto the single table write port with a valid/ready handshake. It also runs a periodic usefulness-clear sweep over all table entries, arbitrated against normal updates.

---
 rtl/vtage_update_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_vtage_update_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtage_update_ctrl.sv
// VTAGE feedback update controller: buffers validation results, computes new
// confidence/usefulness/value fields and serializes them onto the table write port.
module vtage_update_ctrl #(
  parameter int P_NUM_PRED       = 2,
  parameter int P_NUM_ENTRIES    = 1024,
  parameter int P_CONF_WIDTH     = 8,
  parameter int P_U_WIDTH        = 2,
  parameter int P_FIFO_DEPTH     = 4,
  parameter int P_U_RESET_PERIOD = 256,
  localparam int LP_INDEX_WIDTH  = $clog2(P_NUM_ENTRIES)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [P_NUM_PRED-1:0]                         fb_valid_i,
  input  logic [P_NUM_PRED-1:0][31:0]                   fb_actual_i,
  input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]     fb_index_i,
  input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]         fb_conf_i,
  input  logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]          fb_useful_i,
  input  logic [P_NUM_PRED-1:0]                         fb_mispredict_i,
  output logic                                          fb_ready_o,
  output logic                                          wr_valid_o,
  input  logic                                          wr_ready_i,
  output logic [LP_INDEX_WIDTH-1:0]                     wr_index_o,
  output logic [31:0]                                   wr_value_o,
  output logic                                          wr_value_en_o,
  output logic [P_CONF_WIDTH:0]                         wr_conf_o,
  output logic [P_U_WIDTH-1:0]                          wr_useful_o,
  output logic                                          wr_sweep_o,
  output logic                                          sweep_active_o
);

  // state   | meaning
  // UPDATE  | output stage fed from the update FIFO, ucnt counts transfers
  // SWEEP   | output stage walks every entry clearing usefulness, ucnt frozen

  localparam int LP_CW     = P_CONF_WIDTH + 1;
  localparam int LP_PTR_W  = $clog2(P_FIFO_DEPTH);
  localparam int LP_CNT_W  = LP_PTR_W + 1;
  localparam int LP_UCNT_W = $clog2(P_U_RESET_PERIOD + 1);

  localparam logic [LP_CW-1:0]          LP_CMAX      = '1;
  localparam logic [P_U_WIDTH-1:0]      LP_UMAX      = '1;
  localparam logic [LP_INDEX_WIDTH-1:0] LP_LAST_IDX  = LP_INDEX_WIDTH'(P_NUM_ENTRIES - 1);
  localparam logic [LP_UCNT_W-1:0]      LP_UCNT_LAST = LP_UCNT_W'(P_U_RESET_PERIOD - 1);
  localparam logic [LP_CNT_W-1:0]       LP_DEPTH     = LP_CNT_W'(P_FIFO_DEPTH);
  localparam logic [LP_CNT_W-1:0]       LP_NPRED     = LP_CNT_W'(P_NUM_PRED);

  typedef enum logic {ST_UPDATE, ST_SWEEP} state_t;

  typedef struct packed {
    logic [31:0]               actual;
    logic [LP_INDEX_WIDTH-1:0] idx;
    logic [LP_CW-1:0]          conf;
    logic [P_U_WIDTH-1:0]      useful;
    logic                      mispredict;
  } fb_entry_t;

  fb_entry_t             mem [P_FIFO_DEPTH];
  fb_entry_t             head;
  logic [LP_PTR_W-1:0]   wr_ptr, rd_ptr, slot;
  logic [LP_PTR_W-1:0]   lane_slot [P_NUM_PRED];
  logic [LP_CNT_W-1:0]   count, count_n, push_cnt;
  logic                  push, pop, fb_ready_n;

  state_t                state, state_n;
  logic [LP_UCNT_W-1:0]  ucnt, ucnt_n;
  logic                  xfer, feed;

  logic [LP_CW-1:0]          upd_conf;
  logic [P_U_WIDTH-1:0]      upd_useful;
  logic                      upd_ven;
  logic [31:0]               upd_value;

  logic                      nxt_valid, nxt_sweep, nxt_ven;
  logic [LP_INDEX_WIDTH-1:0] nxt_index;
  logic [31:0]               nxt_value;
  logic [LP_CW-1:0]          nxt_conf;
  logic [P_U_WIDTH-1:0]      nxt_useful;

  // Valid lanes pack into consecutive slots in ascending lane order.
  always_comb begin
    slot     = wr_ptr;
    push_cnt = '0;
    for (int l = 0; l < P_NUM_PRED; l++) begin
      lane_slot[l] = slot;
      if (fb_valid_i[l]) begin
        slot     = slot + LP_PTR_W'(1);
        push_cnt = push_cnt + LP_CNT_W'(1);
      end
    end
  end

  assign push = fb_ready_o && (push_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int l = 0; l < P_NUM_PRED; l++) begin
        if (fb_valid_i[l]) begin
          mem[lane_slot[l]] <= '{actual:     fb_actual_i[l],
                                 idx:        fb_index_i[l],
                                 conf:       fb_conf_i[l],
                                 useful:     fb_useful_i[l],
                                 mispredict: fb_mispredict_i[l]};
        end
      end
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    upd_conf   = '0;
    upd_useful = '0;
    upd_ven    = 1'b0;
    upd_value  = '0;
    if (!head.mispredict) begin
      upd_conf   = (head.conf == LP_CMAX) ? LP_CMAX : head.conf + LP_CW'(1);
      upd_useful = (head.useful == LP_UMAX) ? LP_UMAX : head.useful + P_U_WIDTH'(1);
    end else if (head.useful != '0) begin
      upd_useful = head.useful - P_U_WIDTH'(1);
    end else begin
      upd_ven   = 1'b1;
      upd_value = head.actual;
    end
  end

  assign xfer           = wr_valid_o && wr_ready_i;
  assign sweep_active_o = (state == ST_SWEEP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_UPDATE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ucnt_n     = ucnt;
    feed       = 1'b0;
    pop        = 1'b0;
    nxt_valid  = wr_valid_o;
    nxt_sweep  = wr_sweep_o;
    nxt_index  = wr_index_o;
    nxt_conf   = wr_conf_o;
    nxt_useful = wr_useful_o;
    nxt_ven    = wr_value_en_o;
    nxt_value  = wr_value_o;
    case (state)
      ST_UPDATE: begin
        if (xfer) begin
          if (ucnt == LP_UCNT_LAST) begin
            // Sweep write 0 takes the output slot; the FIFO head waits.
            state_n    = ST_SWEEP;
            ucnt_n     = '0;
            nxt_valid  = 1'b1;
            nxt_sweep  = 1'b1;
            nxt_index  = '0;
            nxt_conf   = '0;
            nxt_useful = '0;
            nxt_ven    = 1'b0;
            nxt_value  = '0;
          end else begin
            ucnt_n = ucnt + LP_UCNT_W'(1);
            feed   = 1'b1;
          end
        end else if (!wr_valid_o) begin
          feed = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (xfer) begin
          if (wr_index_o == LP_LAST_IDX) begin
            state_n = ST_UPDATE;
            feed    = 1'b1;
          end else begin
            nxt_index = wr_index_o + LP_INDEX_WIDTH'(1);
          end
        end
      end
    endcase
    if (feed) begin
      pop        = (count != '0);
      nxt_valid  = pop;
      nxt_sweep  = 1'b0;
      nxt_index  = pop ? head.idx   : '0;
      nxt_conf   = pop ? upd_conf   : '0;
      nxt_useful = pop ? upd_useful : '0;
      nxt_ven    = pop ? upd_ven    : 1'b0;
      nxt_value  = pop ? upd_value  : '0;
    end
  end

  // Ready is registered from post-push/pop occupancy, so no path from wr_ready_i.
  assign count_n    = count + (push ? push_cnt : '0) - LP_CNT_W'(pop);
  assign fb_ready_n = (LP_DEPTH - count_n) >= LP_NPRED;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fb_ready_o    <= 1'b1;
      ucnt          <= '0;
      wr_valid_o    <= 1'b0;
      wr_sweep_o    <= 1'b0;
      wr_index_o    <= '0;
      wr_conf_o     <= '0;
      wr_useful_o   <= '0;
      wr_value_en_o <= 1'b0;
      wr_value_o    <= '0;
    end else begin
      if (push) wr_ptr <= slot;
      rd_ptr        <= rd_ptr + LP_PTR_W'(pop);
      count         <= count_n;
      fb_ready_o    <= fb_ready_n;
      ucnt          <= ucnt_n;
      wr_valid_o    <= nxt_valid;
      wr_sweep_o    <= nxt_sweep;
      wr_index_o    <= nxt_index;
      wr_conf_o     <= nxt_conf;
      wr_useful_o   <= nxt_useful;
      wr_value_en_o <= nxt_ven;
      wr_value_o    <= nxt_value;
    end
  end

endmodule

// File: tb/tb_vtage_update_ctrl.sv
// Directed bench for vtage_update_ctrl: table of single-update vectors plus
// sequences for lane order, backpressure, sweep and reset mid-sweep.
module tb_vtage_update_ctrl;
  localparam int NP = 2;
  localparam int IW = 4;
  localparam int CW = 9;
  localparam int UW = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0]           fb_valid;
  logic [NP-1:0][31:0]     fb_actual;
  logic [NP-1:0][IW-1:0]   fb_index;
  logic [NP-1:0][CW-1:0]   fb_conf;
  logic [NP-1:0][UW-1:0]   fb_useful;
  logic [NP-1:0]           fb_misp;
  logic                    fb_ready_o;
  logic                    wr_valid_o;
  logic                    wr_ready;
  logic [IW-1:0]           wr_index_o;
  logic [31:0]             wr_value_o;
  logic                    wr_value_en_o;
  logic [CW-1:0]           wr_conf_o;
  logic [UW-1:0]           wr_useful_o;
  logic                    wr_sweep_o;
  logic                    sweep_active_o;

  int n_cmp  = 0;
  int n_fail = 0;

  vtage_update_ctrl #(
    .P_NUM_PRED(2), .P_NUM_ENTRIES(16), .P_CONF_WIDTH(8), .P_U_WIDTH(2),
    .P_FIFO_DEPTH(4), .P_U_RESET_PERIOD(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .fb_valid_i(fb_valid), .fb_actual_i(fb_actual), .fb_index_i(fb_index),
    .fb_conf_i(fb_conf), .fb_useful_i(fb_useful), .fb_mispredict_i(fb_misp),
    .fb_ready_o(fb_ready_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready), .wr_index_o(wr_index_o),
    .wr_value_o(wr_value_o), .wr_value_en_o(wr_value_en_o), .wr_conf_o(wr_conf_o),
    .wr_useful_o(wr_useful_o), .wr_sweep_o(wr_sweep_o), .sweep_active_o(sweep_active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic          misp;
    logic [31:0]   actual;
    logic [IW-1:0] idx;
    logic [CW-1:0] conf;
    logic [UW-1:0] useful;
    logic [CW-1:0] e_conf;
    logic [UW-1:0] e_useful;
    logic          e_ven;
    logic [31:0]   e_value;
  } vec_t;

  typedef struct {
    logic          sweep;
    logic [IW-1:0] idx;
    logic [CW-1:0] conf;
    logic [UW-1:0] useful;
  } exp_t;

  typedef struct {
    logic [NP-1:0] valid;
    logic [IW-1:0] idx0;
    logic [IW-1:0] idx1;
    logic          sweep_only;
  } grp_t;

  vec_t vecs [7];
  exp_t exp_q [$];
  grp_t plan_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    fb_valid  = '0;
    fb_actual = '0;
    fb_index  = '0;
    fb_conf   = '0;
    fb_useful = '0;
    fb_misp   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_lane(input int lane, input logic misp, input logic [31:0] act,
                          input logic [IW-1:0] idx, input logic [CW-1:0] conf,
                          input logic [UW-1:0] u);
    fb_valid[lane]  = 1'b1;
    fb_misp[lane]   = misp;
    fb_actual[lane] = act;
    fb_index[lane]  = idx;
    fb_conf[lane]   = conf;
    fb_useful[lane] = u;
  endtask

  function automatic logic [CW-1:0] conf_of(input logic [IW-1:0] i);
    return CW'(i) * CW'(3);
  endfunction

  // Correct prediction with useful 0: conf+1, useful 1.
  task automatic exp_upd(input logic [IW-1:0] i);
    exp_q.push_back('{1'b0, i, conf_of(i) + CW'(1), 2'd1});
  endtask

  task automatic exp_sweep(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) exp_q.push_back('{1'b1, IW'(k), '0, '0});
  endtask

  task automatic run_sb(input int budget, input string name);
    exp_t e;
    grp_t g;
    logic full_chk;
    full_chk = 1'b0;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #1;
      if (full_chk) begin
        check({name, "_full_after_push"}, 32'(fb_ready_o), 0);
        full_chk = 1'b0;
      end
      if (wr_valid_o && wr_ready) begin
        e = exp_q.pop_front();
        check({name, "_sweep"},  32'(wr_sweep_o),     32'(e.sweep));
        check({name, "_active"}, 32'(sweep_active_o), 32'(e.sweep));
        check({name, "_idx"},    32'(wr_index_o),     32'(e.idx));
        check({name, "_conf"},   32'(wr_conf_o),      32'(e.conf));
        check({name, "_useful"}, 32'(wr_useful_o),    32'(e.useful));
        check({name, "_ven"},    32'(wr_value_en_o),  0);
        check({name, "_value"},  wr_value_o,          0);
      end
      idle_inputs();
      if (plan_q.size() > 0 && fb_ready_o && (!plan_q[0].sweep_only || sweep_active_o)) begin
        g = plan_q.pop_front();
        if (g.valid[0]) set_lane(0, 1'b0, 32'(g.idx0), g.idx0, conf_of(g.idx0), 2'd0);
        if (g.valid[1]) set_lane(1, 1'b0, 32'(g.idx1), g.idx1, conf_of(g.idx1), 2'd0);
        if (g.sweep_only) full_chk = 1'b1;
      end
    end
    check({name, "_remaining"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    plan_q.delete();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b0, 32'h0,        4'd5,  9'd10,  2'd1, 9'd11,  2'd2, 1'b0, 32'h0};
    vecs[1] = '{1, 1'b0, 32'h0,        4'd9,  9'd511, 2'd3, 9'd511, 2'd3, 1'b0, 32'h0};
    vecs[2] = '{0, 1'b1, 32'hDEADBEEF, 4'd7,  9'd44,  2'd0, 9'd0,   2'd0, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1, 1'b1, 32'h0BADF00D, 4'd2,  9'd300, 2'd2, 9'd0,   2'd1, 1'b0, 32'h0};
    vecs[4] = '{0, 1'b0, 32'h0,        4'd15, 9'd510, 2'd2, 9'd511, 2'd3, 1'b0, 32'h0};
    vecs[5] = '{1, 1'b1, 32'h12345678, 4'd0,  9'd1,   2'd1, 9'd0,   2'd0, 1'b0, 32'h0};
    vecs[6] = '{0, 1'b0, 32'h0,        4'd12, 9'd255, 2'd0, 9'd256, 2'd1, 1'b0, 32'h0};

    rst = 1'b1;
    wr_ready = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check("rst_fb_ready", 32'(fb_ready_o),     1);
    check("rst_wr_valid", 32'(wr_valid_o),     0);
    check("rst_sweep",    32'(wr_sweep_o),     0);
    check("rst_active",   32'(sweep_active_o), 0);
    check("rst_index",    32'(wr_index_o),     0);
    check("rst_conf",     32'(wr_conf_o),      0);
    check("rst_useful",   32'(wr_useful_o),    0);
    check("rst_ven",      32'(wr_value_en_o),  0);
    check("rst_value",    wr_value_o,          0);
    rst = 1'b0;

    // Single updates: two-cycle latency and the update function.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      wr_ready = 1'b1;
      set_lane(vecs[v].lane, vecs[v].misp, vecs[v].actual, vecs[v].idx, vecs[v].conf, vecs[v].useful);
      @(posedge clk);
      #1;
      idle_inputs();
      check($sformatf("tbl%0d_latency", v), 32'(wr_valid_o), 0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", v),  32'(wr_valid_o),    1);
      check($sformatf("tbl%0d_idx", v),    32'(wr_index_o),    32'(vecs[v].idx));
      check($sformatf("tbl%0d_conf", v),   32'(wr_conf_o),     32'(vecs[v].e_conf));
      check($sformatf("tbl%0d_useful", v), 32'(wr_useful_o),   32'(vecs[v].e_useful));
      check($sformatf("tbl%0d_ven", v),    32'(wr_value_en_o), 32'(vecs[v].e_ven));
      check($sformatf("tbl%0d_value", v),  wr_value_o,         vecs[v].e_value);
      check($sformatf("tbl%0d_sweep", v),  32'(wr_sweep_o),    0);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_drained", v), 32'(wr_valid_o), 0);
    end

    // Two lanes in one cycle: lane 0 written before lane 1.
    do_reset();
    wr_ready = 1'b1;
    set_lane(0, 1'b0, 32'h0,        4'd3, 9'd511, 2'd3);
    set_lane(1, 1'b1, 32'hDEADBEEF, 4'd7, 9'd100, 2'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    check("pair_latency", 32'(wr_valid_o), 0);
    @(posedge clk);
    #1;
    check("pair0_idx",    32'(wr_index_o),    3);
    check("pair0_conf",   32'(wr_conf_o),     511);
    check("pair0_useful", 32'(wr_useful_o),   3);
    check("pair0_ven",    32'(wr_value_en_o), 0);
    @(posedge clk);
    #1;
    check("pair1_valid",  32'(wr_valid_o),    1);
    check("pair1_idx",    32'(wr_index_o),    7);
    check("pair1_conf",   32'(wr_conf_o),     0);
    check("pair1_ven",    32'(wr_value_en_o), 1);
    check("pair1_value",  wr_value_o,         32'hDEADBEEF);
    @(posedge clk);
    #1;
    check("pair_drained", 32'(wr_valid_o), 0);

    // Backpressure: ready falls after two accepted pairs, outputs hold, then drain.
    do_reset();
    wr_ready = 1'b0;
    check("bp_ready_c0", 32'(fb_ready_o), 1);
    set_lane(0, 1'b0, 32'h0, 4'd0, 9'd20, 2'd0);
    set_lane(1, 1'b0, 32'h0, 4'd1, 9'd21, 2'd0);
    @(posedge clk);
    #1;
    check("bp_ready_c1", 32'(fb_ready_o), 1);
    set_lane(0, 1'b0, 32'h0, 4'd2, 9'd22, 2'd0);
    set_lane(1, 1'b0, 32'h0, 4'd3, 9'd23, 2'd0);
    @(posedge clk);
    #1;
    check("bp_ready_c2", 32'(fb_ready_o), 0);
    set_lane(0, 1'b0, 32'h0, 4'd8, 9'd28, 2'd0);
    set_lane(1, 1'b0, 32'h0, 4'd9, 9'd29, 2'd0);
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_valid",  32'(wr_valid_o),  1);
      check("bp_hold_idx",    32'(wr_index_o),  0);
      check("bp_hold_conf",   32'(wr_conf_o),   21);
      check("bp_hold_useful", 32'(wr_useful_o), 1);
      check("bp_hold_ready",  32'(fb_ready_o),  0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", 32'(wr_valid_o), 1);
      check("bp_drain_idx",   32'(wr_index_o), 32'(k));
      check("bp_drain_conf",  32'(wr_conf_o),  32'(21 + k));
      check("bp_drain_sweep", 32'(wr_sweep_o), 0);
      @(posedge clk);
      #1;
    end
    // Fourth transfer reaches the period: sweep starts at index 0.
    check("bp_sweep_start",  32'(wr_sweep_o),     1);
    check("bp_sweep_active", 32'(sweep_active_o), 1);
    check("bp_sweep_idx",    32'(wr_index_o),     0);
    check("bp_ready_end",    32'(fb_ready_o),     1);

    // Full sweep with five queued updates and acceptance during the sweep.
    do_reset();
    wr_ready = 1'b1;
    plan_q.push_back('{2'b11, 4'd1, 4'd2, 1'b0});
    plan_q.push_back('{2'b11, 4'd3, 4'd4, 1'b0});
    plan_q.push_back('{2'b01, 4'd5, 4'd0, 1'b0});
    plan_q.push_back('{2'b11, 4'd10, 4'd11, 1'b1});
    exp_upd(4'd1); exp_upd(4'd2); exp_upd(4'd3); exp_upd(4'd4);
    exp_sweep(0, 15);
    exp_upd(4'd5); exp_upd(4'd10); exp_upd(4'd11);
    run_sb(100, "sweep");

    // Reset at sweep index 8, then a fresh count of four transfers.
    do_reset();
    wr_ready = 1'b1;
    plan_q.push_back('{2'b11, 4'd1, 4'd2, 1'b0});
    plan_q.push_back('{2'b11, 4'd3, 4'd4, 1'b0});
    exp_upd(4'd1); exp_upd(4'd2); exp_upd(4'd3); exp_upd(4'd4);
    exp_sweep(0, 7);
    run_sb(100, "pre_rst");
    @(posedge clk);
    #1;
    check("mid_idx",   32'(wr_index_o), 8);
    check("mid_sweep", 32'(wr_sweep_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  32'(wr_valid_o),     0);
    check("mid_rst_sweep",  32'(wr_sweep_o),     0);
    check("mid_rst_active", 32'(sweep_active_o), 0);
    check("mid_rst_ready",  32'(fb_ready_o),     1);
    check("mid_rst_idx",    32'(wr_index_o),     0);
    check("mid_rst_conf",   32'(wr_conf_o),      0);
    @(posedge clk);
    #1 rst = 1'b0;
    plan_q.push_back('{2'b11, 4'd6, 4'd7, 1'b0});
    plan_q.push_back('{2'b11, 4'd8, 4'd9, 1'b0});
    exp_upd(4'd6); exp_upd(4'd7); exp_upd(4'd8); exp_upd(4'd9);
    exp_sweep(0, 1);
    run_sb(100, "post_rst");

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
